acorn128_seq: RTL and testbench

- Bit-serial phase sequencer for ACORN-128. Sits directly upstream of the state-update stage and drives its ca_in, cb_in and mbit_in each step.
- Walks the full cipher schedule, one state step per enabled cycle:
  - key/IV initialization: 1792 steps
  - associated-data absorb plus 256-step pad
  - plaintext encrypt plus 256-step pad
  - finalization: 768 steps
- Captures the 128-bit tag from the keystream bit that the downstream keystream generator returns.

---
 rtl/acorn128_pkg.sv | 27 ++
 rtl/acorn128_tag_cap.sv | 32 +++
 rtl/acorn128_seq.sv | 170 +++++++++++++++++
 tb/tb_acorn128_seq.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/acorn128_pkg.sv
// ACORN-128 sequencer shared types: phase encoding, schedule lengths and counter limits.
// No logic; every constant is sized so that comparisons against the 11-bit step counter stay width-exact.
package acorn128_pkg;

   localparam int INIT_STEPS = 1792;
   localparam int PAD_STEPS  = 256;
   localparam int FIN_STEPS  = 768;
   localparam int TAG_BITS   = 128;
   localparam int STATE_W    = 293;
   localparam int CNT_W      = 11;

   localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_STEPS - 1);
   localparam logic [CNT_W-1:0] PAD_LAST  = CNT_W'(PAD_STEPS - 1);
   localparam logic [CNT_W-1:0] FIN_LAST  = CNT_W'(FIN_STEPS - 1);
   localparam logic [CNT_W-1:0] TAG_FIRST = CNT_W'(FIN_STEPS - TAG_BITS);

   typedef enum logic [2:0] {
      PH_IDLE,
      PH_INIT,
      PH_AD,
      PH_AD_PAD,
      PH_ENC,
      PH_ENC_PAD,
      PH_FIN
   } phase_t;

endpackage

// File: rtl/acorn128_tag_cap.sv
// Serial-in tag register: shifts the keystream bit in at the MSB during the last TAG_BITS finalization
// steps, so the first captured bit lands at bit 0. One-cycle capture latency; no backpressure.
module acorn128_tag_cap
   import acorn128_pkg::*;
(
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_clr,
   input  logic                i_en,
   input  logic [CNT_W-1:0]    i_cnt,
   input  logic                i_bit,
   output logic [TAG_BITS-1:0] o_tag
);

   logic [TAG_BITS-1:0] r_tag;
   logic                w_in_win;

   assign w_in_win = (i_cnt >= TAG_FIRST);

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_tag <= '0;
      end else if (i_clr) begin
         r_tag <= '0;
      end else if (i_en && w_in_win) begin
         r_tag <= {i_bit, r_tag[TAG_BITS-1:1]};
      end
   end

   assign o_tag = r_tag;

endmodule

// File: rtl/acorn128_seq.sv
// ACORN-128 bit-serial phase sequencer: drives ca/cb/mbit for one state step per step_en cycle.
// First step one cycle after start; AD/ENC stall on din_valid low, every other phase steps each cycle.
module acorn128_seq
   import acorn128_pkg::*;
#(
   parameter int LEN_W = 16
)(
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_start,
   input  logic [127:0]        i_key,
   input  logic [127:0]        i_iv,
   input  logic [LEN_W-1:0]    i_ad_len,
   input  logic [LEN_W-1:0]    i_pt_len,
   input  logic                i_din,
   input  logic                i_din_valid,
   output logic                o_din_ready,
   input  logic                i_ks_in,
   output logic                o_step_en,
   output logic                o_ca,
   output logic                o_cb,
   output logic                o_mbit,
   output logic                o_ct_bit,
   output logic                o_ct_valid,
   output logic [TAG_BITS-1:0] o_tag,
   output logic                o_busy,
   output logic                o_done
);

   phase_t             r_phase;
   phase_t             w_nxt_phase;
   logic [CNT_W-1:0]   r_cnt;
   logic [LEN_W-1:0]   r_bits;
   logic [127:0]       r_key;
   logic [127:0]       r_iv;
   logic [LEN_W-1:0]   r_ad_len;
   logic [LEN_W-1:0]   r_pt_len;
   logic               r_mbit_hold;
   logic               r_done;

   logic               w_accept;
   logic               w_step;
   logic               w_ca;
   logic               w_cb;
   logic               w_mbit;
   logic               w_din_rdy;
   logic               w_cnt_clr;
   logic               w_done_nxt;
   logic [LEN_W-1:0]   w_len_m1;

   assign w_accept = (r_phase == PH_IDLE) && i_start;
   assign w_len_m1 = ((r_phase == PH_ENC) ? r_pt_len : r_ad_len) - LEN_W'(1);

   always_comb begin
      w_nxt_phase = r_phase;
      w_step      = 1'b0;
      w_ca        = 1'b0;
      w_cb        = 1'b0;
      w_mbit      = 1'b0;
      w_din_rdy   = 1'b0;
      w_cnt_clr   = 1'b0;
      w_done_nxt  = 1'b0;
      case (r_phase)
         PH_IDLE: begin
            if (i_start) begin
               w_cnt_clr   = 1'b1;
               w_nxt_phase = PH_INIT;
            end
         end
         PH_INIT: begin
            w_step = 1'b1;
            w_ca   = 1'b1;
            w_cb   = 1'b1;
            // Key, then IV, then a single inverted key[0], then the key repeating to the end.
            if (r_cnt < CNT_W'(128))       w_mbit = r_key[r_cnt[6:0]];
            else if (r_cnt < CNT_W'(256))  w_mbit = r_iv[r_cnt[6:0]];
            else if (r_cnt == CNT_W'(256)) w_mbit = ~r_key[0];
            else                           w_mbit = r_key[r_cnt[6:0]];
            if (r_cnt == INIT_LAST) begin
               w_cnt_clr   = 1'b1;
               w_nxt_phase = (r_ad_len == '0) ? PH_AD_PAD : PH_AD;
            end
         end
         PH_AD, PH_ENC: begin
            w_din_rdy = 1'b1;
            w_step    = i_din_valid;
            w_ca      = 1'b1;
            w_cb      = (r_phase == PH_AD);
            w_mbit    = i_din_valid ? i_din : r_mbit_hold;
            if (i_din_valid && (r_bits == w_len_m1)) begin
               w_cnt_clr   = 1'b1;
               w_nxt_phase = (r_phase == PH_AD) ? PH_AD_PAD : PH_ENC_PAD;
            end
         end
         PH_AD_PAD, PH_ENC_PAD: begin
            w_step = 1'b1;
            w_ca   = ~r_cnt[7];
            w_cb   = (r_phase == PH_AD_PAD);
            w_mbit = (r_cnt == '0);
            if (r_cnt == PAD_LAST) begin
               w_cnt_clr = 1'b1;
               if (r_phase == PH_ENC_PAD)   w_nxt_phase = PH_FIN;
               else if (r_pt_len == '0)     w_nxt_phase = PH_ENC_PAD;
               else                         w_nxt_phase = PH_ENC;
            end
         end
         PH_FIN: begin
            w_step = 1'b1;
            w_ca   = 1'b1;
            w_cb   = 1'b1;
            if (r_cnt == FIN_LAST) begin
               w_cnt_clr   = 1'b1;
               w_done_nxt  = 1'b1;
               w_nxt_phase = PH_IDLE;
            end
         end
         default: w_nxt_phase = PH_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_phase     <= PH_IDLE;
         r_cnt       <= '0;
         r_bits      <= '0;
         r_key       <= '0;
         r_iv        <= '0;
         r_ad_len    <= '0;
         r_pt_len    <= '0;
         r_mbit_hold <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_phase <= w_nxt_phase;
         r_done  <= w_done_nxt;
         if (w_accept) begin
            r_key    <= i_key;
            r_iv     <= i_iv;
            r_ad_len <= i_ad_len;
            r_pt_len <= i_pt_len;
         end
         // Data phases count accepted bits in r_bits; r_cnt only tracks fixed-length phases.
         if (w_cnt_clr)                r_cnt <= '0;
         else if (w_step && !w_din_rdy) r_cnt <= r_cnt + CNT_W'(1);
         if (w_cnt_clr)                r_bits <= '0;
         else if (w_step && w_din_rdy)  r_bits <= r_bits + LEN_W'(1);
         if (w_step) r_mbit_hold <= w_mbit;
      end
   end

   acorn128_tag_cap u_tag_cap (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_clr (w_accept),
      .i_en  (w_step && (r_phase == PH_FIN)),
      .i_cnt (r_cnt),
      .i_bit (i_ks_in),
      .o_tag (o_tag)
   );

   assign o_din_ready = w_din_rdy;
   assign o_step_en   = w_step;
   assign o_ca        = w_ca;
   assign o_cb        = w_cb;
   assign o_mbit      = w_mbit;
   assign o_ct_bit    = (r_phase == PH_ENC) && (i_din ^ i_ks_in);
   assign o_ct_valid  = w_step && (r_phase == PH_ENC);
   assign o_busy      = (r_phase != PH_IDLE);
   assign o_done      = r_done;

endmodule

// File: tb/tb_acorn128_seq.sv
// Scoreboard bench for acorn128_seq: each run pushes its full expected step schedule, a monitor
// pops one entry per step_en and checks ca/cb/mbit/ct, plus stalls, done timing and the captured tag.
module tb_acorn128_seq;

   logic         clk = 1'b0;
   logic         i_rst;
   logic         i_start;
   logic [127:0] i_key;
   logic [127:0] i_iv;
   logic [15:0]  i_ad_len;
   logic [15:0]  i_pt_len;
   logic         i_din;
   logic         i_din_valid;
   logic         o_din_ready;
   logic         i_ks_in;
   logic         o_step_en;
   logic         o_ca;
   logic         o_cb;
   logic         o_mbit;
   logic         o_ct_bit;
   logic         o_ct_valid;
   logic [127:0] o_tag;
   logic         o_busy;
   logic         o_done;

   always #5 clk = ~clk;

   acorn128_seq #(.LEN_W(16)) dut (
      .i_clk       (clk),
      .i_rst       (i_rst),
      .i_start     (i_start),
      .i_key       (i_key),
      .i_iv        (i_iv),
      .i_ad_len    (i_ad_len),
      .i_pt_len    (i_pt_len),
      .i_din       (i_din),
      .i_din_valid (i_din_valid),
      .o_din_ready (o_din_ready),
      .i_ks_in     (i_ks_in),
      .o_step_en   (o_step_en),
      .o_ca        (o_ca),
      .o_cb        (o_cb),
      .o_mbit      (o_mbit),
      .o_ct_bit    (o_ct_bit),
      .o_ct_valid  (o_ct_valid),
      .o_tag       (o_tag),
      .o_busy      (o_busy),
      .o_done      (o_done)
   );

   typedef struct packed {
      logic dat;
      logic ca;
      logic cb;
      logic mbit;
      logic ctv;
      logic ctb;
   } exp_t;

   exp_t         q[$];
   exp_t         last_e;
   exp_t         e;
   int           n_tests    = 0;
   int           n_fail     = 0;
   int           done_cnt   = 0;
   int           since_step = 0;
   int           ctv_cnt    = 0;
   int           sidx       = 0;
   logic [127:0] exp_tag;
   logic [63:0]  dat_pat;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic push(input logic dat, ca, cb, mbit, ctv, ctb);
      exp_t x;
      x.dat = dat; x.ca = ca; x.cb = cb; x.mbit = mbit; x.ctv = ctv; x.ctb = ctb;
      q.push_back(x);
   endtask

   // Expected schedule; the bench drives ks_in = (global step index)&1, din = dat_pat[accepted bit].
   task automatic push_sched(input logic [127:0] key, input logic [127:0] iv, input int ad, input int pt);
      int g;
      int fin_off;
      for (int c = 0; c < 1792; c++) begin
         if (c < 128)       push(0, 1, 1, key[c], 0, 0);
         else if (c < 256)  push(0, 1, 1, iv[c-128], 0, 0);
         else if (c == 256) push(0, 1, 1, ~key[0], 0, 0);
         else               push(0, 1, 1, key[c%128], 0, 0);
      end
      for (int j = 0; j < ad; j++)  push(1, 1, 1, dat_pat[j], 0, 0);
      for (int c = 0; c < 256; c++) push(0, c < 128, 1, c == 0, 0, 0);
      for (int j = 0; j < pt; j++) begin
         g = 1792 + ad + 256 + j;
         push(1, 1, 0, dat_pat[ad+j], 1, dat_pat[ad+j] ^ g[0]);
      end
      for (int c = 0; c < 256; c++) push(0, c < 128, 0, c == 0, 0, 0);
      for (int c = 0; c < 768; c++) push(0, 1, 1, 0, 0, 0);
      fin_off = 1792 + ad + 256 + pt + 256;
      for (int i = 0; i < 128; i++) begin
         g = fin_off + 640 + i;
         exp_tag[i] = g[0];
      end
   endtask

   initial begin : monitor
      forever begin
         @(negedge clk);
         #2;
         if (o_done) begin
            done_cnt++;
            chk("done_gap", since_step, 1);
            chk("tag", o_tag, exp_tag);
            chk("sched_left", q.size(), 0);
         end
         if (q.size() > 0) chk($sformatf("din_ready@%0d", sidx), o_din_ready, q[0].dat);
         if (o_step_en) begin
            if (q.size() == 0) begin
               chk("extra_step", o_step_en, 0);
            end else begin
               e = q.pop_front();
               chk($sformatf("ca@%0d", sidx), o_ca, e.ca);
               chk($sformatf("cb@%0d", sidx), o_cb, e.cb);
               chk($sformatf("mbit@%0d", sidx), o_mbit, e.mbit);
               chk($sformatf("ct_valid@%0d", sidx), o_ct_valid, e.ctv);
               if (e.ctv) chk($sformatf("ct_bit@%0d", sidx), o_ct_bit, e.ctb);
               if (o_ct_valid) ctv_cnt++;
               last_e = e;
               sidx++;
            end
         end else if (o_din_ready && q.size() > 0) begin
            chk($sformatf("stall_ca@%0d", sidx), o_ca, q[0].ca);
            chk($sformatf("stall_cb@%0d", sidx), o_cb, q[0].cb);
            chk($sformatf("stall_mbit@%0d", sidx), o_mbit, last_e.mbit);
         end
         since_step = o_step_en ? 1 : since_step + 1;
      end
   end

   task automatic run(input logic [127:0] key, input logic [127:0] iv, input int ad, input int pt,
                      input bit tog, input int abort_at, input int poke_at);
      int k, j, cyc, total, dc0;
      total = 1792 + ad + 256 + pt + 256 + 768;
      push_sched(key, iv, ad, pt);
      sidx = 0;
      ctv_cnt = 0;
      dc0 = done_cnt;
      @(negedge clk);
      i_key = key; i_iv = iv; i_ad_len = 16'(ad); i_pt_len = 16'(pt); i_start = 1'b1;
      k = 0; j = 0; cyc = 0;
      while (k < total && cyc < total + 2000) begin
         @(negedge clk);
         if (k == abort_at) begin
            q.delete();
            i_rst = 1'b0;
            #2;
            chk("abort_busy", o_busy, 0);
            chk("abort_step_en", o_step_en, 0);
            chk("abort_tag", o_tag, 0);
            @(negedge clk);
            i_rst = 1'b1;
            return;
         end
         i_start     = (k == poke_at);
         i_din_valid = tog ? cyc[0] : 1'b1;
         i_din       = dat_pat[j];
         i_ks_in     = k[0];
         #1;
         if (o_step_en) begin
            if (o_din_ready) j++;
            k++;
         end
         cyc++;
      end
      i_start = 1'b0;
      chk("step_count", k, total);
      repeat (10) @(negedge clk);
      chk("done_once", done_cnt - dc0, 1);
      chk("enc_steps", ctv_cnt, pt);
      chk("idle_after", o_busy, 0);
   endtask

   initial begin : stim
      int dc;
      dat_pat     = 64'h0000_0000_00C3_5A4D;
      exp_tag     = '0;
      last_e      = '0;
      i_rst       = 1'b0;
      i_start     = 1'b0;
      i_key       = '0;
      i_iv        = '0;
      i_ad_len    = '0;
      i_pt_len    = '0;
      i_din       = 1'b0;
      i_din_valid = 1'b0;
      i_ks_in     = 1'b0;
      @(negedge clk);
      #2;
      chk("rst_busy", o_busy, 0);
      chk("rst_step_en", o_step_en, 0);
      chk("rst_ca", o_ca, 0);
      chk("rst_cb", o_cb, 0);
      chk("rst_mbit", o_mbit, 0);
      chk("rst_din_ready", o_din_ready, 0);
      chk("rst_done", o_done, 0);
      chk("rst_ct_valid", o_ct_valid, 0);
      chk("rst_tag", o_tag, 0);
      @(negedge clk);
      i_rst = 1'b1;
      repeat (3) @(negedge clk);

      // AD=8, PT=16, din_valid toggling, a stray start during FIN; tag = AAAA..AAAA.
      run(128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0, 128'h00112233_44556677_8899AABB_CCDDEEFF,
          8, 16, 1'b1, -1, 1792 + 8 + 256 + 16 + 256 + 100);
      chk("tag_hold", o_tag, 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA);

      // Reset at INIT cnt=500 aborts the run with no done.
      dc = done_cnt;
      run(128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000, 128'h1234, 0, 0, 1'b0, 500, -1);
      repeat (20) @(negedge clk);
      chk("abort_no_done", done_cnt - dc, 0);
      chk("abort_idle", o_busy, 0);
      chk("abort_tag_clear", o_tag, 0);

      // key=1, empty AD/PT: 3072 steps, full INIT after the aborted run.
      run(128'h1, 128'h0, 0, 0, 1'b0, -1, -1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
